// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - request/response channel pair for one requester of the shared ALU
interface alu_share_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic [OP_W-1:0]   req_op;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational ALU between two requesters
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    alu_share_arbiter_if.slave  p0,
    alu_share_arbiter_if.slave  p1,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [OP_W-1:0]     alu_op,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic                alu_zero
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        state;
    logic              owner;
    logic              last_grant;
    logic [DATA_W-1:0] res_q;
    logic              zero_q;
    logic [1:0]        rsp_valid_q;

    logic rsp_hs;
    logic any_valid;
    logic grant;
    logic accept;

    // A new op may only be taken while idle or in the very cycle the owner drains its result.
    always_comb begin
        rsp_hs    = (state == S_RESP) && (owner ? p1.rsp_ready : p0.rsp_ready);
        any_valid = p0.req_valid | p1.req_valid;
        grant     = (p0.req_valid && p1.req_valid) ? ~last_grant : p1.req_valid;
        accept    = !rst && any_valid && ((state == S_IDLE) || rsp_hs);
    end

    assign p0.req_ready  = accept & ~grant;
    assign p1.req_ready  = accept & grant;

    assign p0.rsp_valid  = rsp_valid_q[0];
    assign p1.rsp_valid  = rsp_valid_q[1];
    assign p0.rsp_result = res_q;
    assign p1.rsp_result = res_q;
    assign p0.rsp_zero   = zero_q;
    assign p1.rsp_zero   = zero_q;

    // alu_a/alu_b/alu_op double as the operand registers, so the ALU sees stable inputs in EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            owner       <= 1'b0;
            last_grant  <= 1'b1;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            res_q       <= '0;
            zero_q      <= 1'b0;
            rsp_valid_q <= 2'b00;
        end else begin
            if (accept) begin
                alu_a      <= grant ? p1.req_a  : p0.req_a;
                alu_b      <= grant ? p1.req_b  : p0.req_b;
                alu_op     <= grant ? p1.req_op : p0.req_op;
                owner      <= grant;
                last_grant <= grant;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    res_q       <= alu_result;
                    zero_q      <= alu_zero;
                    rsp_valid_q <= owner ? 2'b10 : 2'b01;
                    state       <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_hs) begin
                        rsp_valid_q <= 2'b00;
                        state       <= accept ? S_EXEC : S_IDLE;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    rsp_valid_q <= 2'b00;
                end
            endcase
        end
    end
endmodule
